// File: rtl/spi_adc_frame_rx_if.sv
// Bundle between the ADC capture stage and its surroundings: the SPI pins plus the sample valid/ready port.
// The DUT takes the slave modport; whatever drives ena/sdata_in and consumes samples takes master.
interface spi_adc_frame_rx_if #(
  parameter int DATA_BITS = 12
);
  logic                 ena;
  logic                 sdata_in;
  logic                 sclk_n;
  logic                 cs_n;
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 overrun;
  logic                 clr_ovr;
  logic                 busy;

  modport master (
    output ena, sdata_in, sample_ready, clr_ovr,
    input  sclk_n, cs_n, sample, sample_valid, overrun, busy
  );

  modport slave (
    input  ena, sdata_in, sample_ready, clr_ovr,
    output sclk_n, cs_n, sample, sample_valid, overrun, busy
  );
endinterface

// File: rtl/spi_adc_frame_rx.sv
// SPI master capture for a serial ADC: counter-derived sclk_n, synchronised MSB-first shift-in,
// and sample extraction into a one-entry valid/ready buffer with a sticky overrun flag.
module spi_adc_frame_rx #(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_BITS   = 16,
  parameter int DATA_BITS    = 12,
  parameter int LEAD_BITS    = 4,
  parameter int QUIET_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input logic               clk,
  input logic               rst_a,
  spi_adc_frame_rx_if.slave io
);
  localparam int CNT_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(FRAME_BITS + 1);
  // Lead bits fall off the top of this register, so only data + trailing bits are kept.
  localparam int FW      = FRAME_BITS - LEAD_BITS;

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, QUIET} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bit;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [FW-1:0]          r_frame;
  logic                   r_cs_n;
  logic                   r_sclk_n;
  logic                   r_busy;
  logic [DATA_BITS-1:0]   r_sample;
  logic                   r_valid;
  logic                   r_ovr;

  logic w_sd;
  logic w_load;
  logic w_xfer;

  assign w_sd   = r_sync[SYNC_STAGES-1];
  assign w_load = (r_state == SHIFT) && r_sclk_n && (r_cnt == DIV_LAST) && (r_bit == BIT_LAST);
  assign w_xfer = r_valid & io.sample_ready;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= io.sdata_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Capture happens on the same edge that drives sclk_n low, a full high half after the device update.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_frame  <= '0;
      r_cs_n   <= 1'b1;
      r_sclk_n <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io.ena) begin
            r_state <= CS_SETUP;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        CS_SETUP: begin
          if (r_cnt == DIV_LAST) begin
            r_state  <= SHIFT;
            r_sclk_n <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_frame  <= FW'({r_frame, w_sd});
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        SHIFT: begin
          if (r_cnt != DIV_LAST) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= '0;
            if (!r_sclk_n) begin
              r_sclk_n <= 1'b1;
            end else if (r_bit == BIT_LAST) begin
              r_state <= QUIET;
              r_cs_n  <= 1'b1;
            end else begin
              r_sclk_n <= 1'b0;
              r_bit    <= r_bit + BW'(1);
              r_frame  <= FW'({r_frame, w_sd});
            end
          end
        end
        QUIET: begin
          if (r_cnt == QUIET_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // A load coinciding with a transfer is a clean handover; only an unconsumed overwrite flags overrun.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_load) begin
        r_sample <= r_frame[FW-1 -: DATA_BITS];
        r_valid  <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_load && r_valid && !io.sample_ready) r_ovr <= 1'b1;
      else if (io.clr_ovr)                       r_ovr <= 1'b0;
    end
  end

  assign io.cs_n         = r_cs_n;
  assign io.sclk_n       = r_sclk_n;
  assign io.busy         = r_busy;
  assign io.sample       = r_sample;
  assign io.sample_valid = r_valid;
  assign io.overrun      = r_ovr;
endmodule

// File: tb/tb_spi_adc_frame_rx.sv
// Bench for spi_adc_frame_rx: default instance driven through directed scenarios, plus a
// CLK_DIV=2 / SYNC_STAGES=1 instance run on random frames with jittered device timing.
module tb_spi_adc_frame_rx;
  localparam int FB = 16;
  localparam int LB = 4;
  localparam int DB = 12;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  spi_adc_frame_rx_if #(.DATA_BITS(DB)) a_if();
  spi_adc_frame_rx_if #(.DATA_BITS(DB)) b_if();

  spi_adc_frame_rx dut_a (.clk(clk), .rst_a(rst_a), .io(a_if.slave));
  spi_adc_frame_rx #(.CLK_DIV(2), .SYNC_STAGES(1)) dut_b (.clk(clk), .rst_a(rst_b), .io(b_if.slave));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Sample field: drop the lead bits at the top and the trailing bits at the bottom.
  function automatic logic [DB-1:0] ref_sample(input logic [FB-1:0] w);
    return DB'(w >> (FB - LB - DB));
  endfunction

  // Frame words for the default instance, consumed one per cs_n falling edge.
  logic [FB-1:0] a_words [16];
  int            a_wr = 0;
  int            a_rd = 0;
  logic [FB-1:0] a_cur;

  logic [FB-1:0] b_words [128];
  int            b_nfr = 0;
  logic [FB-1:0] b_cur;

  // ADC model: bit 0 right after cs_n falls, bit i around the rising edge of sclk_n pulse i-1.
  initial begin : dev_a
    logic pc, ps, pend, pv;
    time  pend_t;
    int   idx;
    pc = 1'b1; ps = 1'b1; pend = 1'b0; pv = 1'b0; pend_t = 0; idx = 0;
    a_if.sdata_in = 1'b0;
    forever begin
      #2;
      if (pend && $time >= pend_t) begin
        a_if.sdata_in = pv;
        pend = 1'b0;
      end
      if (pc === 1'b1 && a_if.cs_n === 1'b0) begin
        if (a_rd < a_wr) begin
          a_cur = a_words[a_rd];
          a_rd++;
        end else begin
          a_cur = '0;
        end
        idx = 0;
        pend = 1'b0;
        a_if.sdata_in = a_cur[FB-1];
      end else if (a_if.cs_n === 1'b0 && ps === 1'b1 && a_if.sclk_n === 1'b0) begin
        idx++;
        if (idx < FB) pv = a_cur[FB-1-idx];
        else          pv = 1'($urandom);
        pend_t = $time + 40;
        pend = 1'b1;
      end
      pc = a_if.cs_n;
      ps = a_if.sclk_n;
    end
  end

  initial begin : dev_b
    logic pc, ps, pend, pv;
    time  pend_t;
    int   idx;
    pc = 1'b1; ps = 1'b1; pend = 1'b0; pv = 1'b0; pend_t = 0; idx = 0;
    b_if.sdata_in = 1'b0;
    b_cur = '0;
    forever begin
      #2;
      if (pend && $time >= pend_t) begin
        b_if.sdata_in = pv;
        pend = 1'b0;
      end
      if (pc === 1'b1 && b_if.cs_n === 1'b0) begin
        b_cur = FB'($urandom);
        if (b_nfr < 128) b_words[b_nfr] = b_cur;
        b_nfr++;
        idx = 0;
        pend = 1'b0;
        b_if.sdata_in = b_cur[FB-1];
      end else if (b_if.cs_n === 1'b0 && ps === 1'b1 && b_if.sclk_n === 1'b0) begin
        idx++;
        if (idx < FB) pv = b_cur[FB-1-idx];
        else          pv = 1'($urandom);
        // Nominal update is 2 cycles after the fall; jitter spans roughly one cycle either side.
        pend_t = $time + time'(12 + 2 * $urandom_range(0, 8));
        pend = 1'b1;
      end
      pc = b_if.cs_n;
      ps = b_if.sclk_n;
    end
  end

  int   mon_cs_low = 0, mon_sclk_fall = 0, mon_cs_fall = 0, mon_valid = 0;
  logic [DB-1:0] mon_last = '0;
  logic m_pc = 1'b1, m_ps = 1'b1;
  always @(negedge clk) begin
    if (a_if.cs_n === 1'b0) mon_cs_low++;
    if (a_if.cs_n === 1'b0 && m_pc === 1'b1) mon_cs_fall++;
    if (a_if.sclk_n === 1'b0 && m_ps === 1'b1) mon_sclk_fall++;
    if (a_if.sample_valid === 1'b1) mon_valid++;
    if (a_if.sample_valid === 1'b1 && a_if.sample_ready === 1'b1) mon_last = a_if.sample;
    m_pc = a_if.cs_n;
    m_ps = a_if.sclk_n;
  end

  task automatic wait_cs_low();
    int n = 0;
    while (a_if.cs_n !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("wait_cs_timeout", 32'(a_if.cs_n), 32'd0);
  endtask

  // Leaves the caller on the negedge just before the edge that loads the sample buffer.
  task automatic wait_load();
    wait_cs_low();
    repeat (131) @(negedge clk);
  endtask

  task automatic pulse_ena();
    @(negedge clk);
    a_if.ena = 1'b1;
    @(negedge clk);
    a_if.ena = 1'b0;
  endtask

  initial begin
    int s_cs_low, s_sclk, s_cs_fall, s_valid, bad, n, got, guard, xbad;
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.ena = 1'b0; a_if.sample_ready = 1'b0; a_if.clr_ovr = 1'b0;
    b_if.ena = 1'b0; b_if.sample_ready = 1'b0; b_if.clr_ovr = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(a_if.cs_n), 32'd1);
    chk("rst_sclk_n", 32'(a_if.sclk_n), 32'd1);
    chk("rst_valid", 32'(a_if.sample_valid), 32'd0);
    chk("rst_overrun", 32'(a_if.overrun), 32'd0);
    chk("rst_busy", 32'(a_if.busy), 32'd0);
    chk("rst_sample", 32'(a_if.sample), 32'd0);
    rst_a = 1'b0;
    s_sclk = mon_sclk_fall;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (a_if.cs_n !== 1'b1 || a_if.sclk_n !== 1'b1 || a_if.sample_valid !== 1'b0 ||
          a_if.overrun !== 1'b0 || a_if.busy !== 1'b0) bad++;
    end
    chk("idle_outputs", 32'(bad), 32'd0);
    chk("idle_sclk_edges", 32'(mon_sclk_fall - s_sclk), 32'd0);

    // Single frame on a one-cycle ena pulse
    a_words[a_wr] = 16'h0ABC; a_wr++;
    a_if.sample_ready = 1'b1;
    s_cs_low = mon_cs_low; s_sclk = mon_sclk_fall; s_cs_fall = mon_cs_fall; s_valid = mon_valid;
    pulse_ena();
    repeat (300) @(negedge clk);
    chk("single_cs_low_cycles", 32'(mon_cs_low - s_cs_low), 32'd132);
    chk("single_sclk_falls", 32'(mon_sclk_fall - s_sclk), 32'd16);
    chk("single_frames", 32'(mon_cs_fall - s_cs_fall), 32'd1);
    chk("single_valid_cycles", 32'(mon_valid - s_valid), 32'd1);
    chk("single_sample", 32'(mon_last), 32'(ref_sample(16'h0ABC)));

    // Overrun, set-beats-clear, and load coinciding with a transfer
    a_words[a_wr] = 16'h0123; a_wr++;
    a_words[a_wr] = 16'h0456; a_wr++;
    a_words[a_wr] = 16'h0789; a_wr++;
    a_if.sample_ready = 1'b0;
    @(negedge clk);
    a_if.ena = 1'b1;
    wait_load();
    @(negedge clk);
    chk("ovr_f1_sample", 32'(a_if.sample), 32'(ref_sample(16'h0123)));
    chk("ovr_f1_valid", 32'(a_if.sample_valid), 32'd1);
    chk("ovr_f1_overrun", 32'(a_if.overrun), 32'd0);
    wait_load();
    a_if.clr_ovr = 1'b1;
    @(negedge clk);
    a_if.clr_ovr = 1'b0;
    chk("ovr_f2_sample", 32'(a_if.sample), 32'(ref_sample(16'h0456)));
    chk("ovr_f2_valid", 32'(a_if.sample_valid), 32'd1);
    chk("ovr_f2_set_wins", 32'(a_if.overrun), 32'd1);
    @(negedge clk);
    a_if.clr_ovr = 1'b1;
    @(negedge clk);
    a_if.clr_ovr = 1'b0;
    chk("ovr_cleared", 32'(a_if.overrun), 32'd0);
    chk("ovr_sample_stable", 32'(a_if.sample), 32'(ref_sample(16'h0456)));
    wait_load();
    a_if.sample_ready = 1'b1;
    @(negedge clk);
    a_if.ena = 1'b0;
    chk("handover_sample", 32'(a_if.sample), 32'(ref_sample(16'h0789)));
    chk("handover_valid", 32'(a_if.sample_valid), 32'd1);
    chk("handover_overrun", 32'(a_if.overrun), 32'd0);
    @(negedge clk);
    chk("handover_drained", 32'(a_if.sample_valid), 32'd0);
    repeat (10) @(negedge clk);

    // Reset in the middle of bit 7
    a_words[a_wr] = 16'hFF0F; a_wr++;
    a_words[a_wr] = 16'h0777; a_wr++;
    pulse_ena();
    wait_cs_low();
    repeat (62) @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("abort_cs_n", 32'(a_if.cs_n), 32'd1);
    chk("abort_sclk_n", 32'(a_if.sclk_n), 32'd1);
    chk("abort_valid", 32'(a_if.sample_valid), 32'd0);
    chk("abort_busy", 32'(a_if.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    pulse_ena();
    wait_load();
    @(negedge clk);
    chk("abort_next_sample", 32'(a_if.sample), 32'(ref_sample(16'h0777)));
    chk("abort_next_valid", 32'(a_if.sample_valid), 32'd1);
    repeat (10) @(negedge clk);

    // Back-to-back frames, lead bits ignored, cs_n gap
    a_words[a_wr] = 16'hF555; a_wr++;
    a_words[a_wr] = 16'h0AAA; a_wr++;
    @(negedge clk);
    a_if.ena = 1'b1;
    wait_load();
    @(negedge clk);
    chk("b2b_f1_sample", 32'(a_if.sample), 32'(ref_sample(16'hF555)));
    n = 0;
    while (a_if.cs_n === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_cs_high_cycles", 32'(n), 32'd3);
    a_if.ena = 1'b0;
    wait_load();
    @(negedge clk);
    chk("b2b_f2_sample", 32'(a_if.sample), 32'(ref_sample(16'h0AAA)));
    chk("b2b_overrun", 32'(a_if.overrun), 32'd0);
    repeat (10) @(negedge clk);
    chk("b2b_stopped_busy", 32'(a_if.busy), 32'd0);
    chk("b2b_stopped_cs_n", 32'(a_if.cs_n), 32'd1);

    // Fast variant on random frames with jittered device timing
    rst_b = 1'b0;
    b_if.sample_ready = 1'b1;
    b_if.ena = 1'b1;
    got = 0; guard = 0; xbad = 0;
    while (got < 100 && guard < 12000) begin
      @(negedge clk);
      guard++;
      if ($isunknown({b_if.cs_n, b_if.sclk_n, b_if.sample, b_if.sample_valid, b_if.overrun, b_if.busy}))
        xbad++;
      if (b_if.sample_valid === 1'b1) begin
        chk("rand_sample", 32'(b_if.sample), 32'(ref_sample(b_words[got])));
        got++;
      end
    end
    b_if.ena = 1'b0;
    chk("rand_count", 32'(got), 32'd100);
    chk("rand_no_x", 32'(xbad), 32'd0);
    chk("rand_overrun", 32'(b_if.overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_adc_frame_rx.md
Name: spi_adc_frame_rx

Overview:
SPI master capture stage for a serial ADC. It generates chip-select (cs_n) and a counter-derived serial clock (sclk_n) from clk, and passes the asynchronous ADC data line through a synchroniser. It assembles each frame MSB-first, extracts the sample field, and presents it to the downstream datapath through a one-entry valid/ready buffer with a sticky overrun flag. The serial clock is never gated or derived combinationally from clk.

Parameters:
CLK_DIV, 4, clk cycles per sclk_n half period; must be >= SYNC_STAGES+1
FRAME_BITS, 16, sclk_n pulses per frame
DATA_BITS, 12, sample width
LEAD_BITS, 4, bits discarded at frame start; LEAD_BITS+DATA_BITS <= FRAME_BITS, trailing bits discarded
QUIET_CYCLES, 2, clk cycles cs_n held high after each frame
SYNC_STAGES, 2, flops in the sdata_in synchroniser (>=1)

Ports:
clk  in  1  system clock
rst_a  in  1  reset
ena  in  1  conversion request, sampled in IDLE
sdata_in  in  1  ADC serial data, asynchronous to clk
sclk_n  out  1  serial clock, idles high, registered
cs_n  out  1  chip select, active low, registered
sample  out  DATA_BITS  captured sample
sample_valid  out  1  sample holds unconsumed data
sample_ready  in  1  downstream accepts sample
overrun  out  1  sticky: unconsumed sample overwritten
clr_ovr  in  1  clears overrun
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset rst_a: asynchronous, active-high. Clock clk: all state on its rising edge.
- Reset values: cs_n=1, sclk_n=1, sample=0, sample_valid=0, overrun=0, busy=0, synchroniser flops=0, state=IDLE. Reset mid-frame aborts at once and discards the partial frame; no sample_valid results.
- FSM states: IDLE, CS_SETUP, SHIFT, QUIET.
- IDLE: cs_n=1, sclk_n=1. If ena=1, go to CS_SETUP on the next edge. If ena=0, stay.
- CS_SETUP: cs_n=0, sclk_n=1 for CLK_DIV cycles, then go to SHIFT.
- SHIFT: FRAME_BITS bit periods. Each bit period is sclk_n low for CLK_DIV cycles, then high for CLK_DIV cycles.
- ADC device contract: bit 0 is valid after the cs_n falling edge; bit i is valid after the rising edge of sclk_n pulse i-1.
- Capture: the synchroniser output is shifted into the frame register on the edge that drives sclk_n low for bit i (bit 0 is captured at the CS_SETUP→SHIFT edge). Exactly FRAME_BITS captures per frame.
- After the last high half, go to QUIET: cs_n=1 for QUIET_CYCLES, then IDLE.
- With defaults, cs_n is low for 4+128=132 cycles. Continuous conversion with ena held high gives a 135-cycle period (cs_n high 3 cycles: QUIET plus one IDLE cycle).
- ena deasserted mid-frame: the frame completes normally and no new frame starts.
- Extraction: sample = frame bits LEAD_BITS .. LEAD_BITS+DATA_BITS-1, counted MSB-first, with the first captured data bit as sample MSB. Lead bits are ignored regardless of value.
- Output buffer: the sample register is loaded on the edge entering QUIET. sample_valid is set by that same edge.
- A transfer occurs on a cycle with sample_valid & sample_ready; sample_valid clears on the next edge unless a new load happens on the same edge.
- Load while sample_valid=1 and no transfer that cycle: sample is overwritten, sample_valid stays 1, overrun is set.
- Load on the same cycle as a transfer: the new sample is loaded, sample_valid stays 1, overrun is not set.
- overrun stays set until clr_ovr=1 at an edge. If a set and a clear fall in the same cycle, the set wins.
- sample is stable while sample_valid=1 and no load occurs.

Test Plan:
1. Reset with ena=0 for 50 cycles -> cs_n=1, sclk_n=1, sample_valid=0, overrun=0, busy=0 throughout. No sclk_n edges.
2. Device model frame 0x0ABC, ena pulsed for 1 cycle, sample_ready=1 -> cs_n low exactly 132 cycles, 16 sclk_n falling edges, sample=0xABC, sample_valid high for exactly 1 cycle, no second frame.
3. ena held, sample_ready=0, frames 0x0123 then 0x0456 -> after frame 1, sample=0x123 with overrun=0; after frame 2, sample=0x456, sample_valid=1, overrun=1. clr_ovr pulse -> overrun=0.
4. rst_a asserted during bit 7 of a frame -> cs_n=1, sclk_n=1 immediately, sample_valid=0. After release with ena=1, the next frame 0x0777 yields sample=0x777 (no residue from the aborted frame).
5. ena held, sample_ready=1, frames 0xF555 then 0x0AAA -> samples 0x555 then 0xAAA (lead bits ignored). cs_n high exactly 3 cycles between frames; overrun stays 0.
6. Variant CLK_DIV=2, SYNC_STAGES=1, sdata_in edges jittered ±1 cycle around the device-update instant -> sample equals the model value on 100 random frames; no X on any output.
